// File: rtl/riscv_pkg.sv
// Shared RISC-V load/store encodings, LSU state type and request-legality helpers.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // size is funct3[1:0]: 00 byte, 01 half, 10 word
  function automatic logic addr_aligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b01:   return !lo[0];
      2'b10:   return lo == 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half of a memory word and sign/zero-extends it.
module load_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data = {24'd0, byte_sel};
      F3_HU:   data = {16'd0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: validates the access, drives one memory
// request with timeout, and returns aligned load data with a done/err pulse.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_t    state;
  logic [CW-1:0] wait_cnt;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [1:0]    lane_q;
  logic          access_ok;
  logic [3:0]    be_next;
  logic [31:0]   wd_next;
  logic [31:0]   load_data;

  assign access_ok = f3_legal(req_we, funct3) && addr_aligned(funct3[1:0], addr[1:0]);
  assign stall     = !rst && (((state == IDLE) && req_valid) || (state == REQ));

  always_comb begin
    be_next = 4'b1111;
    wd_next = wdata;
    if (req_we) begin
      case (funct3)
        F3_B: begin
          be_next = 4'b0001 << addr[1:0];
          wd_next = {4{wdata[7:0]}};
        end
        F3_H: begin
          be_next = 4'b0011 << addr[1:0];
          wd_next = {2{wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  load_align u_align (
    .funct3 (f3_q),
    .lane   (lane_q),
    .word   (mem_rdata),
    .data   (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      we_q      <= 1'b0;
      f3_q      <= '0;
      lane_q    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (req_valid) begin
            we_q   <= req_we;
            f3_q   <= funct3;
            lane_q <= addr[1:0];
            if (access_ok) begin
              state     <= REQ;
              wait_cnt  <= '0;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= be_next;
              mem_wdata <= wd_next;
            end else begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
              rdata <= '0;
            end
          end
        end
        REQ: begin
          // ack is checked before the timeout so a coincident ack still succeeds
          if (mem_ack || (wait_cnt == LAST_WAIT)) begin
            state     <= DONE;
            done      <= 1'b1;
            err       <= !mem_ack;
            rdata     <= (mem_ack && !we_q) ? load_data : '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a short timeout and a reactive memory model.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          lat;
    int          nreq;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_legal(input logic we, input logic [2:0] f3);
    if (we) return f3 <= 3'd2;
    return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic logic [3:0] model_be(input logic we, input logic [2:0] f3, input int lane);
    logic [3:0] r;
    int sz;
    if (!we) return 4'hF;
    sz = 1 << f3[1:0];
    for (int i = 0; i < 4; i++) r[i] = (i >= lane) && (i < lane + sz);
    return r;
  endfunction

  function automatic logic [31:0] model_wd(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int sz;
    sz = 1 << f3[1:0];
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int lane, input logic [31:0] w);
    logic [31:0] t;
    t = w >> (8 * lane);
    case (f3)
      3'd0:    return 32'($signed(t[7:0]));
      3'd1:    return 32'($signed(t[15:0]));
      3'd4:    return 32'(t[7:0]);
      3'd5:    return 32'(t[15:0]);
      default: return w;
    endcase
  endfunction

  // ack_at: REQ cycle (1-based) in which mem_ack is returned; 0 = never
  task automatic run_op(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] mw, input int ack_at);
    exp_t e, g;
    int   lane, sz, nreq, lat;
    bit   seen;
    lane = int'(a[1:0]);
    sz   = 1 << f3[1:0];
    if (!model_legal(we, f3) || (lane % sz) != 0) e = '{1'b1, 32'd0, 1, 0};
    else if (ack_at >= 1 && ack_at <= TO)           e = '{1'b0, we ? 32'd0 : model_load(f3, lane, mw), ack_at + 1, ack_at};
    else                                            e = '{1'b1, 32'd0, TO + 1, TO};
    sb_q.push_back(e);

    @(negedge clk);
    req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
    mem_rdata = mw; mem_ack = 1'b0;
    #1;
    check({tag, ".stall0"}, 32'(stall), 32'd1);
    nreq = 0; seen = 0; lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      req_valid = 1'b0; mem_ack = 1'b0;
      #1;
      if (done) begin
        seen = 1; lat = c;
        break;
      end
      check({tag, ".stall"}, 32'(stall), 32'd1);
      if (mem_req) begin
        nreq++;
        check({tag, ".we"},   32'(mem_we), 32'(we));
        check({tag, ".addr"}, mem_addr, a & 32'hFFFF_FFFC);
        check({tag, ".be"},   32'(mem_be), 32'(model_be(we, f3, lane)));
        if (we) check({tag, ".wdata"}, mem_wdata, model_wd(f3, wd));
        mem_ack = (nreq == ack_at);
      end
    end
    if (!seen) check({tag, ".done_seen"}, 32'd0, 32'd1);
    g = sb_q.pop_front();
    check({tag, ".err"},   32'(err), 32'(g.err));
    check({tag, ".rdata"}, rdata, g.rd);
    check({tag, ".lat"},   32'(lat), 32'(g.lat));
    check({tag, ".nreq"},  32'(nreq), 32'(g.nreq));
    check({tag, ".stall_done"}, 32'(stall), 32'd0);
    check({tag, ".mreq_done"},  32'(mem_req), 32'd0);
    mem_ack = 1'b1;  // stray ack outside REQ must be ignored
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check({tag, ".pulse"}, 32'(done), 32'd0);
    check({tag, ".idle_stall"}, 32'(stall), 32'd0);
    check({tag, ".hold"}, rdata, g.rd);
    check({tag, ".idle_mreq"}, 32'(mem_req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; funct3 = '0; addr = '0; wdata = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.rdata", rdata, 32'd0);
    check("rst.mem_req", 32'(mem_req), 32'd0);
    check("rst.mem_we", 32'(mem_we), 32'd0);
    check("rst.mem_be", 32'(mem_be), 32'd0);
    check("rst.mem_addr", mem_addr, 32'd0);
    check("rst.mem_wdata", mem_wdata, 32'd0);
    req_valid = 1'b0;
    rst = 1'b0;

    run_op("lw",      1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 1);
    run_op("lb",      1'b0, 3'd0, 32'h103, 32'h0, 32'h80FFFFFF, 1);
    run_op("lbu",     1'b0, 3'd4, 32'h103, 32'h0, 32'h80FFFFFF, 2);
    run_op("sh",      1'b1, 3'd1, 32'h102, 32'h1234ABCD, 32'h0, 1);
    run_op("lw_mis",  1'b0, 3'd2, 32'h101, 32'h0, 32'h11111111, 1);
    run_op("lh_mis",  1'b0, 3'd1, 32'h103, 32'h0, 32'h11111111, 1);
    run_op("tmo",     1'b0, 3'd2, 32'h200, 32'h0, 32'hCAFEF00D, 0);
    run_op("ack_tmo", 1'b0, 3'd2, 32'h204, 32'h0, 32'hCAFEF00D, TO);
    run_op("ld_ill",  1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 1);
    run_op("st_ill",  1'b1, 3'd4, 32'h100, 32'h55, 32'h0, 1);
    run_op("lh",      1'b0, 3'd1, 32'h302, 32'h0, 32'h80017FFF, 3);
    run_op("lhu",     1'b0, 3'd5, 32'h302, 32'h0, 32'h80017FFF, 1);
    run_op("sb",      1'b1, 3'd0, 32'h101, 32'hA5A5A5C3, 32'h0, 2);
    run_op("sw",      1'b1, 3'd2, 32'h104, 32'h01234567, 32'h0, 1);
    run_op("sw_tmo",  1'b1, 3'd2, 32'h108, 32'h89ABCDEF, 32'h0, 0);

    for (int n = 0; n < 24; n++) begin
      run_op("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             $urandom, $urandom, $urandom, int'($urandom_range(0, TO + 1)));
    end

    // reset in the middle of an outstanding access
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; funct3 = 3'd2; addr = 32'h400; mem_ack = 1'b0;
    repeat (2) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    #1;
    check("mid.mem_req_before", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("mid.mem_req", 32'(mem_req), 32'd0);
    check("mid.stall", 32'(stall), 32'd0);
    check("mid.done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      check("mid.no_done", 32'(done), 32'd0);
      check("mid.idle", 32'(stall | mem_req), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255: maximum number of cycles spent waiting for mem_ack before the access is aborted.
REQ-002 The block SHALL have these ports, clock and reset first:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  the current instruction is a load or store.
- req_we  in  1  1 = store, 0 = load.
- funct3  in  3  RISC-V access size and sign encoding.
- addr  in  32  byte address from the EX ALU result.
- wdata  in  32  store data from register read port 2.
- stall  out  1  holds PC and register write-back while an access is in flight.
- done  out  1  one-cycle pulse: access complete, rdata/err valid.
- err  out  1  with done: misaligned, illegal funct3, or timeout.
- rdata  out  32  aligned, extended load result for WB.
- mem_req  out  1  memory request, level.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  word address, bits [1:0] = 0.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  memory read word.
- mem_ack  in  1  memory completion.

Function
REQ-003 The FSM SHALL have three states: IDLE, REQ and DONE.
REQ-004 In IDLE with req_valid=1, the block SHALL capture req_we, funct3, addr and wdata.
REQ-005 From IDLE with a legal, aligned request, the FSM SHALL go to REQ; an illegal or misaligned request SHALL go directly to DONE with err=1 and no memory access.
REQ-006 Legal loads SHALL be funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal stores SHALL be 000 SB, 001 SH, 010 SW.
REQ-007 Alignment: LH/LHU/SH SHALL require addr[0]=0; LW/SW SHALL require addr[1:0]=00.
REQ-008 stall SHALL equal (state==IDLE && req_valid) || state==REQ, combinational.
REQ-009 In REQ, mem_req SHALL be 1 (registered) and all mem_* outputs SHALL stay stable until mem_ack is sampled high.
REQ-010 mem_ack SHALL be ignored outside REQ.
REQ-011 In REQ, mem_ack=1 SHALL move the FSM to DONE; mem_req SHALL be 0 in the DONE cycle.
REQ-012 A wait counter SHALL be cleared on entering REQ and increment each REQ cycle without ack.
REQ-013 When the wait counter reaches TIMEOUT_CYCLES without ack, the FSM SHALL go to DONE with err=1 and rdata=0.
REQ-014 If mem_ack and the timeout occur in the same cycle, mem_ack SHALL win.
REQ-015 In DONE, done SHALL be 1 and stall SHALL be 0; the next state SHALL be IDLE unconditionally, and req_valid in DONE SHALL be ignored.
REQ-016 Latency SHALL be 2 cycles minimum from req_valid to done (ack in the first REQ cycle); misaligned or illegal requests SHALL take 1 cycle.
REQ-017 Stores SHALL drive mem_be = 0001<<addr[1:0] for SB, 0011<<addr[1:0] for SH, and 1111 for SW.
REQ-018 Store data SHALL be replicated across lanes: {4{wdata[7:0]}} for SB, {2{wdata[15:0]}} for SH, and wdata for SW.
REQ-019 Loads SHALL drive mem_be=1111.
REQ-020 rdata SHALL be registered on ack: the byte at lane addr[1:0] or the half at lane addr[1], sign-extended for LB/LH, zero-extended for LBU/LHU.
REQ-021 rdata SHALL be 0 for stores and for err.
REQ-022 rdata SHALL hold its value until the next done.

Reset
REQ-023 rst=1 SHALL force, asynchronously: state=IDLE, counter=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, rdata=0, done=0, err=0.
REQ-024 Reset during REQ SHALL abandon the access without completion.
REQ-025 While rst=1, stall SHALL be 0.

Structure
REQ-026 funct3 constants and state encodings SHALL live in shared package riscv_pkg.
REQ-027 Byte/half extraction and extension SHALL be a combinational sub-module named load_align.

Verification
REQ-028 LW addr=0x100, mem_rdata=0xDEADBEEF, ack in the first REQ cycle -> done at cycle 2, rdata=0xDEADBEEF, err=0, stall high for cycles 0-1.
REQ-029 LB addr=0x103 with mem_rdata=0x80FFFFFF -> rdata=0xFFFFFF80; LBU at the same address -> rdata=0x00000080.
REQ-030 SH addr=0x102, wdata=0x1234ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1.
REQ-031 LW addr=0x101 -> done and err in cycle 1, mem_req never asserted.
REQ-032 TIMEOUT_CYCLES=4, ack never returned -> err with done after 4 REQ cycles, rdata=0; a separate run with ack coincident with the timeout -> err=0.
REQ-033 rst asserted mid-REQ -> mem_req=0 immediately, no done pulse, state=IDLE.
